// File: rtl/fm_mem_pkg.sv
// Shared constants and types for the feature-map DRM buffer and its read/write masters.
package fm_mem_pkg;

    localparam int FM_DATA_WIDTH   = 8;
    localparam int FM_CONV_OUT_NUM = 18;
    localparam int FM_WORD_W       = FM_CONV_OUT_NUM * FM_DATA_WIDTH;
    localparam int FM_ADDR_W       = 13;

    // DRM read latency; the write-side controller refers to the same value.
    localparam int FM_RD_LATENCY   = 2;

    typedef enum logic [1:0] {
        FM_IDLE,
        FM_ISSUE,
        FM_DRAIN,
        FM_FINISH
    } fm_rd_state_t;

endpackage

// File: rtl/fm_sync_fifo.sv
// Small register-based FIFO with fall-through head; the caller guarantees no
// push when full and no pop when empty.
module fm_sync_fifo #(
    parameter int WIDTH = 144,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [DEPTH-1:0] wr_sel;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wsel
            assign wr_sel[gi] = push && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= push_data;
                end
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fm_stream_reader.sv
// Feature-map DRM read master: issues sequential reads, absorbs the fixed read
// latency and hands words to the conv engine as a credit-limited stream.
module fm_stream_reader #(
    parameter int DATA_WIDTH   = fm_mem_pkg::FM_DATA_WIDTH,
    parameter int CONV_OUT_NUM = fm_mem_pkg::FM_CONV_OUT_NUM,
    parameter int FM_MEM_DEPTH = fm_mem_pkg::FM_ADDR_W,
    parameter int RD_LATENCY   = fm_mem_pkg::FM_RD_LATENCY,
    parameter int FIFO_DEPTH   = 4,
    localparam int W = CONV_OUT_NUM * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [FM_MEM_DEPTH-1:0] base_addr,
    input  logic [FM_MEM_DEPTH:0]   word_cnt,
    output logic [FM_MEM_DEPTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [W-1:0]          rd_data,
    output logic [W-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    import fm_mem_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]           DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]         ONE_C   = CW'(1);
    localparam logic [FM_MEM_DEPTH:0] LAST_C  = (FM_MEM_DEPTH + 1)'(1);

    fm_rd_state_t                state_reg;
    logic [FM_MEM_DEPTH-1:0]     cur_addr_reg;
    logic [FM_MEM_DEPTH:0]       remaining_reg;
    logic [FM_MEM_DEPTH-1:0]     rd_addr_reg;
    logic                        busy_reg;
    logic                        done_reg;
    logic [RD_LATENCY-1:0]       vld_pipe_reg;

    logic [CW-1:0]               fifo_count;
    logic [CW-1:0]               inflight;
    logic [CW:0]                 occupancy;
    logic                        issue;
    logic                        pop;
    logic                        drained;

    // Stage 0 of the valid pipe is the registered rd_en itself.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(vld_pipe_reg[i]);
        end
    end

    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
    assign issue     = (state_reg == FM_ISSUE) && (occupancy < DEPTH_C);
    assign pop       = out_valid && out_ready;
    // True on the edge that retires the final outstanding word.
    assign drained   = (inflight == '0) &&
                       ((fifo_count == '0) || ((fifo_count == ONE_C) && pop));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe_reg <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                vld_pipe_reg[i] <= vld_pipe_reg[i-1];
            end
            vld_pipe_reg[0] <= issue;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= FM_IDLE;
            cur_addr_reg  <= '0;
            remaining_reg <= '0;
            rd_addr_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                FM_IDLE: begin
                    if (start) begin
                        cur_addr_reg  <= base_addr;
                        remaining_reg <= word_cnt;
                        busy_reg      <= 1'b1;
                        // Zero-length commands retire through DRAIN, which
                        // completes at once, so busy is seen for one cycle.
                        state_reg     <= (word_cnt == '0) ? FM_DRAIN : FM_ISSUE;
                    end
                end
                FM_ISSUE: begin
                    if (issue) begin
                        rd_addr_reg   <= cur_addr_reg;
                        cur_addr_reg  <= cur_addr_reg + 1'b1;
                        remaining_reg <= remaining_reg - 1'b1;
                        if (remaining_reg == LAST_C) begin
                            state_reg <= FM_DRAIN;
                        end
                    end
                end
                FM_DRAIN: begin
                    if (drained) begin
                        state_reg <= FM_FINISH;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                FM_FINISH: begin
                    state_reg <= FM_IDLE;
                end
                default: begin
                    state_reg <= FM_IDLE;
                end
            endcase
        end
    end

    fm_sync_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (vld_pipe_reg[RD_LATENCY-1]),
        .push_data (rd_data),
        .pop       (pop),
        .head      (out_data),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign rd_addr   = rd_addr_reg;
    assign rd_en     = vld_pipe_reg[0];
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_fm_stream_reader.sv
// Directed bench for fm_stream_reader against a queue-based stream model and a
// behavioural DRM with the fixed read latency.
module tb_fm_stream_reader;

    localparam int AW = 13;
    localparam int W  = 144;
    localparam int FIFO_DEPTH = 4;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_cnt;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    fm_stream_reader dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: address in both the low and high bits of the word.
    function automatic logic [W-1:0] word_of(input logic [AW-1:0] a);
        return {a, 118'b0, a};
    endfunction

    // DRM: address registered on the edge after issue, data valid one cycle later.
    always @(posedge clk) rd_data <= word_of(rd_addr);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic [AW-1:0] exp_addr_q[$];
    logic [W-1:0]  exp_data_q[$];
    logic [AW-1:0] rd_addr_log[$];
    int first_rden_cyc, first_valid_cyc, first_hs_cyc, last_hs_cyc, done_cyc;
    int hs_count, done_count, busy_cycles, outstanding, max_out, t_start;
    logic [W-1:0] last_hs_data;
    logic [W-1:0] hold_d;
    bit hold_v = 1'b0;
    bit bp_mode = 1'b0;
    int bp_phase = 0;

    task automatic clear_stats();
        first_rden_cyc = -1; first_valid_cyc = -1; first_hs_cyc = -1;
        last_hs_cyc = -1; done_cyc = -1;
        hs_count = 0; done_count = 0; busy_cycles = 0; max_out = 0;
        last_hs_data = '0;
        rd_addr_log.delete();
    endtask

    // Per-cycle compare against the stream model.
    always @(negedge clk) begin
        if (!rstn) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", W'(out_valid), W'(1));
                chk("stall_data", out_data, hold_d);
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            if (busy) busy_cycles++;
            if (rd_en) begin
                if (first_rden_cyc < 0) first_rden_cyc = cyc;
                rd_addr_log.push_back(rd_addr);
                outstanding++;
                chk("outstanding_le_depth", W'(outstanding <= FIFO_DEPTH), W'(1));
                chk("rd_en_expected", W'(exp_addr_q.size() != 0), W'(1));
                if (exp_addr_q.size() != 0) chk("rd_addr", W'(rd_addr), W'(exp_addr_q.pop_front()));
            end
            if (outstanding > max_out) max_out = outstanding;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                chk("data_expected", W'(exp_data_q.size() != 0), W'(1));
                if (exp_data_q.size() != 0) chk("out_data", out_data, exp_data_q.pop_front());
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc  = cyc;
                last_hs_data = out_data;
                hs_count++;
                outstanding--;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_mode) begin
                out_ready = (bp_phase == 0);
                bp_phase  = (bp_phase == 2) ? 0 : bp_phase + 1;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n, input bit accept);
        logic [AW-1:0] a;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; word_cnt = n;
        if (accept) begin
            for (int i = 0; i < int'(n); i++) begin
                a = b + AW'(i);
                exp_addr_q.push_back(a);
                exp_data_q.push_back(word_of(a));
            end
        end
        @(posedge clk); #1;
        t_start = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_count == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_timeout", W'(done_count != 0), W'(1));
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("hs_timeout", W'(hs_count >= target), W'(1));
    endtask

    task automatic end_checks(input string tag, input int words);
        chk({tag, "_hs_count"}, W'(hs_count), W'(words));
        chk({tag, "_done_count"}, W'(done_count), W'(1));
        chk({tag, "_queues_empty"}, W'(exp_addr_q.size() + exp_data_q.size()), W'(0));
        chk({tag, "_idle_after"}, W'(busy), W'(0));
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0;
        outstanding = 0;
        clear_stats();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rd_addr", W'(rd_addr), W'(0));
        chk("rst_rd_en", W'(rd_en), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data", out_data, W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Basic read, full throughput.
        clear_stats();
        do_start(13'd0, 14'd16, 1'b1);
        wait_done(100);
        end_checks("basic", 16);
        chk("basic_first_rd_en", W'(first_rden_cyc - t_start), W'(1));
        chk("basic_first_valid", W'(first_valid_cyc - t_start), W'(3));
        chk("basic_rate", W'(last_hs_cyc - first_hs_cyc), W'(15));
        chk("basic_done_after_last", W'(done_cyc - last_hs_cyc), W'(1));
        chk("basic_last_word_lo", W'(last_hs_data[12:0]), W'(15));
        $display("basic: base=0 cnt=16 words=%0d done_cnt=%0d", hs_count, done_count);

        // Backpressure with ready asserted one cycle in three.
        clear_stats();
        bp_mode = 1'b1; bp_phase = 0;
        do_start(13'd40, 14'd20, 1'b1);
        wait_done(400);
        bp_mode = 1'b0;
        end_checks("bp", 20);
        chk("bp_max_outstanding", W'(max_out), W'(4));
        $display("backpressure: base=40 cnt=20 words=%0d max_outstanding=%0d", hs_count, max_out);

        // Address wrap.
        clear_stats();
        do_start(13'd8190, 14'd4, 1'b1);
        wait_done(100);
        end_checks("wrap", 4);
        chk("wrap_addr_count", W'(rd_addr_log.size()), W'(4));
        if (rd_addr_log.size() == 4) begin
            chk("wrap_addr0", W'(rd_addr_log[0]), W'(8190));
            chk("wrap_addr1", W'(rd_addr_log[1]), W'(8191));
            chk("wrap_addr2", W'(rd_addr_log[2]), W'(0));
            chk("wrap_addr3", W'(rd_addr_log[3]), W'(1));
        end
        chk("wrap_last_word_hi", W'(last_hs_data[143:131]), W'(1));
        $display("wrap: base=8190 cnt=4 words=%0d", hs_count);

        // Zero length.
        clear_stats();
        do_start(13'd5, 14'd0, 1'b1);
        wait_done(20);
        end_checks("zero", 0);
        chk("zero_no_rd_en", W'(first_rden_cyc == -1), W'(1));
        chk("zero_busy_cycles", W'(busy_cycles), W'(1));
        chk("zero_done_time", W'(done_cyc - t_start), W'(1));
        $display("zero: cnt=0 busy_cycles=%0d done_cnt=%0d", busy_cycles, done_count);

        // Start while busy is ignored.
        clear_stats();
        do_start(13'd200, 14'd16, 1'b1);
        repeat (4) @(posedge clk);
        do_start(13'd100, 14'd8, 1'b0);
        wait_done(100);
        repeat (20) @(posedge clk);
        #1;
        end_checks("busy_start", 16);
        $display("start_while_busy: words=%0d done_cnt=%0d", hs_count, done_count);

        // Reset mid-transfer, then a short command.
        clear_stats();
        do_start(13'd300, 14'd16, 1'b1);
        wait_hs(7, 100);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_rd_en", W'(rd_en), W'(0));
        chk("midrst_rd_addr", W'(rd_addr), W'(0));
        exp_addr_q.delete();
        exp_data_q.delete();
        outstanding = 0;
        repeat (2) @(posedge clk);
        #3;
        chk("midrst_no_done", W'(done_count), W'(0));
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        clear_stats();
        do_start(13'd500, 14'd3, 1'b1);
        wait_done(50);
        end_checks("post_rst", 3);
        $display("reset_restart: base=500 cnt=3 words=%0d done_cnt=%0d", hs_count, done_count);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
